regfile_scoreboard: RTL and testbench



---
 rtl/regfile_scoreboard.sv | 129 ++++++++++++
 tb/tb_regfile_scoreboard.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: register file with x0 hardwiring, post-reset clear sequencer and busy scoreboard.
// Optional same-cycle write-to-read bypass is enabled by defining REGFILE_BYPASS_EN.
`default_nettype none

module regfile_scoreboard #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int DEPTH  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] rs1_addr,
   input  logic [ADDR_W-1:0] rs2_addr,
   output logic [DATA_W-1:0] rs1_data,
   output logic [DATA_W-1:0] rs2_data,
   output logic              rs1_busy,
   output logic              rs2_busy,
   input  logic              issue_we,
   input  logic [ADDR_W-1:0] issue_addr,
   input  logic              reg_we,
   input  logic [ADDR_W-1:0] w_addr,
   input  logic [DATA_W-1:0] w_data,
   output logic              ready
);

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W + 1)'(DEPTH);

   typedef enum logic [0:0] {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } state_t;

   state_t              state_q;
   state_t              state_d;
   logic [ADDR_W-1:0]   clr_idx;
   logic [DATA_W-1:0]   mem [DEPTH];
   logic [DEPTH-1:0]    busy;
   logic                running;
   logic                wr_ok;
   logic                iss_ok;

   // Address 0 and addresses beyond the array are never stored or tracked.
   function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
      return (a != '0) && ({1'b0, a} < DEPTH_C);
   endfunction

   assign running = (state_q == RUN) && !rst;
   assign wr_ok   = running && reg_we && addr_ok(w_addr);
   assign iss_ok  = running && issue_we && addr_ok(issue_addr);
   assign ready   = running;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= CLEAR;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         CLEAR:   if (clr_idx == LAST_IDX) state_d = RUN;
         RUN:     state_d = RUN;
         default: state_d = CLEAR;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clr_idx <= '0;
      end else if (state_q == CLEAR) begin
         clr_idx <= (clr_idx == LAST_IDX) ? '0 : clr_idx + 1'b1;
      end
   end

   // Array carries no reset; the clear sequencer zeroes it after every reset.
   always_ff @(posedge clk) begin
      if (state_q == CLEAR) begin
         mem[clr_idx] <= '0;
      end else if (wr_ok) begin
         mem[w_addr] <= w_data;
      end
   end

   // Issue is applied after writeback so a same-address collision leaves the register busy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy <= '0;
      end else if (state_q == RUN) begin
         if (wr_ok)  busy[w_addr]     <= 1'b0;
         if (iss_ok) busy[issue_addr] <= 1'b1;
      end
   end

   always_comb begin
      rs1_data = '0;
      rs1_busy = 1'b0;
      if (running && addr_ok(rs1_addr)) begin
         rs1_data = mem[rs1_addr];
         rs1_busy = busy[rs1_addr];
`ifdef REGFILE_BYPASS_EN
         if (wr_ok && (w_addr == rs1_addr)) begin
            rs1_data = w_data;
            rs1_busy = iss_ok && (issue_addr == rs1_addr);
         end
`endif
      end
   end

   always_comb begin
      rs2_data = '0;
      rs2_busy = 1'b0;
      if (running && addr_ok(rs2_addr)) begin
         rs2_data = mem[rs2_addr];
         rs2_busy = busy[rs2_addr];
`ifdef REGFILE_BYPASS_EN
         if (wr_ok && (w_addr == rs2_addr)) begin
            rs2_data = w_data;
            rs2_busy = iss_ok && (issue_addr == rs2_addr);
         end
`endif
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: directed and random stimulus against an array/flag reference model.
`default_nettype none

module tb_regfile_scoreboard;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int DP = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic [AW-1:0] rs1_addr, rs2_addr, issue_addr, w_addr;
   logic [DW-1:0] rs1_data, rs2_data, w_data;
   logic          rs1_busy, rs2_busy, issue_we, reg_we, ready;

   int checks = 0;
   int fails  = 0;

   logic [DW-1:0] m_mem [DP];
   bit            m_busy [DP];
   bit            m_run;
   int            m_cnt;

   regfile_scoreboard #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DP)) dut (
      .clk(clk), .rst(rst),
      .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
      .rs1_data(rs1_data), .rs2_data(rs2_data),
      .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
      .issue_we(issue_we), .issue_addr(issue_addr),
      .reg_we(reg_we), .w_addr(w_addr), .w_data(w_data),
      .ready(ready)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      checks++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] a);
      if (!m_run || a == 0 || int'(a) >= DP) return '0;
`ifdef REGFILE_BYPASS_EN
      if (reg_we && w_addr == a) return w_data;
`endif
      return m_mem[a];
   endfunction

   function automatic logic [DW-1:0] exp_busy(input logic [AW-1:0] a);
      if (!m_run || a == 0 || int'(a) >= DP) return '0;
`ifdef REGFILE_BYPASS_EN
      if (reg_we && w_addr == a) return {31'd0, issue_we && issue_addr == a};
`endif
      return {31'd0, m_busy[a]};
   endfunction

   task automatic model_reset();
      m_run = 0;
      m_cnt = 0;
      for (int i = 0; i < DP; i++) m_busy[i] = 0;
   endtask

   // Reference behaviour at each rising edge, from the register-file rules.
   task automatic model_edge();
      if (!m_run) begin
         m_cnt++;
         if (m_cnt == DP) begin
            m_run = 1;
            for (int i = 0; i < DP; i++) m_mem[i] = '0;
         end
      end else begin
         if (reg_we && w_addr != 0) begin
            m_mem[w_addr]  = w_data;
            m_busy[w_addr] = 0;
         end
         if (issue_we && issue_addr != 0) m_busy[issue_addr] = 1;
      end
   endtask

   task automatic drive(input bit ie, input logic [AW-1:0] ia, input bit we,
                        input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        input logic [AW-1:0] a1, input logic [AW-1:0] a2);
      issue_we = ie; issue_addr = ia; reg_we = we; w_addr = wa; w_data = wd;
      rs1_addr = a1; rs2_addr = a2;
      #1;
      check("rs1_data", rs1_data, exp_data(a1));
      check("rs2_data", rs2_data, exp_data(a2));
      check("rs1_busy", {31'd0, rs1_busy}, exp_busy(a1));
      check("rs2_busy", {31'd0, rs2_busy}, exp_busy(a2));
      check("ready", {31'd0, ready}, {31'd0, m_run});
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic idle(input logic [AW-1:0] a1, input logic [AW-1:0] a2);
      drive(0, 0, 0, 0, '0, a1, a2);
   endtask

   initial begin
      rst = 1'b1;
      issue_we = 0; issue_addr = 0; reg_we = 0; w_addr = 0; w_data = 0;
      rs1_addr = 0; rs2_addr = 0;
      model_reset();
      repeat (3) @(negedge clk);
      #1;
      check("reset_ready", {31'd0, ready}, '0);
      check("reset_rs1_data", rs1_data, '0);
      @(negedge clk);
      rst = 1'b0;

      // Writes during the clear sequence must be ignored.
      repeat (DP) drive(0, 0, 1, 5'd3, 32'hDEADBEEF, 5'd3, 5'd0);
      idle(5'd3, 5'd0);

      drive(0, 0, 1, 5'd5, 32'h12345678, 5'd1, 5'd5);
      idle(5'd1, 5'd5);
      drive(0, 0, 1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd5);
      idle(5'd0, 5'd5);

      drive(1, 5'd7, 0, 0, '0, 5'd7, 5'd0);
      idle(5'd7, 5'd7);
      drive(0, 0, 1, 5'd7, 32'hA5A5A5A5, 5'd7, 5'd6);
      idle(5'd7, 5'd6);

      drive(1, 5'd9, 0, 0, '0, 5'd9, 5'd0);
      drive(1, 5'd9, 1, 5'd9, 32'h1, 5'd9, 5'd9);
      idle(5'd9, 5'd0);
      drive(0, 0, 1, 5'd9, 32'h2, 5'd9, 5'd0);

      drive(0, 0, 1, 5'd4, 32'h11111111, 5'd4, 5'd0);
      drive(0, 0, 1, 5'd4, 32'h0BADF00D, 5'd4, 5'd4);
      idle(5'd4, 5'd0);
      drive(1, 5'd0, 0, 0, '0, 5'd0, 5'd0);

      for (int n = 0; n < 400; n++) begin
         drive($urandom_range(0, 1), AW'($urandom_range(0, 7)),
               $urandom_range(0, 1), AW'($urandom_range(0, 7)), DW'($urandom),
               AW'($urandom_range(0, 7)), AW'($urandom_range(0, 31)));
      end

      // Asynchronous reset between edges while x2/x3 are busy.
      drive(1, 5'd2, 0, 0, '0, 5'd2, 5'd3);
      drive(1, 5'd3, 0, 0, '0, 5'd2, 5'd3);
      #1;
      check("pre_rst_busy1", {31'd0, rs1_busy}, 32'd1);
      check("pre_rst_busy2", {31'd0, rs2_busy}, 32'd1);
      #2 rst = 1'b1;
      #1;
      model_reset();
      check("async_busy1", {31'd0, rs1_busy}, '0);
      check("async_busy2", {31'd0, rs2_busy}, '0);
      check("async_ready", {31'd0, ready}, '0);
      check("async_data1", rs1_data, '0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (DP) idle(5'd2, 5'd3);
      for (int a = 0; a < DP; a += 2) idle(AW'(a), AW'(a + 1));

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

`default_nettype wire
